img_stream_seq: RTL
===================

// Module: img_stream_seq
// PURPOSE
// Frame sequencer between a 1-cycle-latency pixel source (file reader / line memory)
// and the capture -> 3x3 window pipeline. Gates source reads after a start-up delay,
// frames the data as AXI4-Stream video (tuser = SOF, tlast = EOL), inserts
// horizontal/vertical blanking, counts frames, and absorbs downstream back-pressure
// in a credit-controlled 4-entry FIFO.
// PARAMETERS
// DATA_WIDTH   8     pixel width
// IMG_WIDTH    2560  pixels per line (>=1)
// IMG_HEIGHT   1440  lines per frame (>=1)
// START_DELAY  16    idle cycles between start and the first read (0 allowed)
// H_BLANK      0     idle cycles after the last read of a line (0 allowed)
// V_BLANK      0     idle cycles after the last read of a frame (0 allowed)
// NUM_FRAMES   1     frames to send; 0 = free-running
// PORTS
// clk            in   1           single clock domain
// reset          in   1           asynchronous, active-high
// start          in   1           1-cycle pulse; honoured only in IDLE
// src_rd_en      out  1           read request to the pixel source
// src_valid      in   1           source data valid, exactly 1 cycle after src_rd_en
// src_data       in   DATA_WIDTH  source pixel
// m_axis_tdata   out  DATA_WIDTH  pixel
// m_axis_tvalid  out  1
// m_axis_tready  in   1
// m_axis_tuser   out  1           first pixel of frame
// m_axis_tlast   out  1           last pixel of line
// busy           out  1           state != IDLE/DONE, or FIFO non-empty
// frame_done     out  1           1-cycle pulse when a frame's last pixel handshakes out
// frame_cnt      out  16          completed frames (wraps at 2^16)
// err            out  1           sticky: src_valid with no outstanding read
// BEHAVIOUR
// - Reset (async): all outputs 0, FSM = IDLE, counters 0, FIFO and in-flight tag cleared.
// - FSM: IDLE -start-> DELAY (START_DELAY cycles; skipped if 0) -> ACTIVE.
//   ACTIVE: src_rd_en = 1 when credit ok; col++ per read. On the IMG_WIDTH-th read:
//   last row -> VBLANK, else -> HBLANK. HBLANK/VBLANK count H_BLANK/V_BLANK cycles
//   from the cycle after that read (0 -> direct). HBLANK -> ACTIVE (row++, col=0).
//   VBLANK -> ACTIVE (row=0) if NUM_FRAMES==0 or frames issued < NUM_FRAMES, else DONE.
//   DONE -> IDLE once the FIFO is empty; a new start is accepted again in IDLE.
// - Credit: issue only if fifo_count + inflight < 4 (inflight in {0,1}); FIFO never
//   overflows. With tready held 1: one pixel per clock, no bubbles within a line.
// - Tags {sof, eol} are computed at issue (sof = row0 col0, eol = col IMG_WIDTH-1),
//   delayed one cycle, and written into the FIFO with src_data on src_valid.
// - Latency: src_rd_en at cycle t -> src_valid t+1 -> m_axis_tvalid t+2 (registered).
// - Output: AXI rules; tdata/tuser/tlast stable while tvalid & ~tready; tvalid never
//   drops without a handshake. Simultaneous FIFO push and pop: count unchanged.
// - frame_cnt / frame_done update on handshake of the tuser... eol pixel of last row.
// - src_valid with inflight==0: data dropped, err set (cleared only by reset).
// - start while not IDLE: ignored. tready low during blanking: FSM continues; blanking
//   is not stretched, reads stall only on credit.
// - Counter widths: $clog2(IMG_WIDTH), $clog2(IMG_HEIGHT), $clog2(max delay)+1.
// STRUCTURE
// - Shared package img_pkg: FSM state encoding (IDLE, DELAY, ACTIVE, HBLANK, VBLANK,
//   DONE), SEQ_FIFO_DEPTH = 4, tag struct {sof, eol}.
// - One sub-module: stream_credit_fifo (depth 4, width DATA_WIDTH+2, registered
//   output, count output); FSM, counters, tag pipe stay in the top.
// TESTING  (IMG_WIDTH=4, IMG_HEIGHT=2, START_DELAY=3, H_BLANK=2, V_BLANK=5, NUM_FRAMES=2)
// 1 start @c0, tready=1, source echoes 0..15 -> first src_rd_en @c4, tvalid @c6 with
//   tdata 0 tuser 1; tlast on 3, 7; 2 idle read cycles between lines; 5 after frame.
// 2 Same run -> frame_done pulses twice, frame_cnt=2, 16 pixels out, busy falls, IDLE.
// 3 tready toggled 1010 / held 0 for 20 cycles -> no loss/dup, src_rd_en stops after
//   4 credits, output order and tags identical to case 1.
// 4 reset asserted mid-line 2 -> outputs 0 same cycle; after release, start restarts
//   with tuser on first pixel, frame_cnt=0.
// 5 start pulsed during ACTIVE and DONE -> ignored; NUM_FRAMES=0 -> runs >3 frames.
// 6 spurious src_valid in IDLE -> err=1, FIFO empty, tvalid stays 0.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the image stream sequencer.
//   seq_state_t    : sequencer FSM states
//   SEQ_FIFO_DEPTH : output FIFO depth, also the total read-credit budget
//   pix_tag_t      : per-pixel framing tag carried alongside the data
//   clog2_min1     : counter width helper that never returns zero
package img_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK,
    ST_DONE
  } seq_state_t;

  localparam int SEQ_FIFO_DEPTH = 4;

  typedef struct packed {
    logic sof;  // first pixel of frame
    logic eol;  // last pixel of line
  } pix_tag_t;

  // A counter over 'value' positions needs $clog2(value) bits, but a
  // zero-width vector is illegal, so degenerate sizes get one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/stream_credit_fifo.sv
// Small first-word-fall-through FIFO used as the output skid buffer.
//   clk, reset  : clock, asynchronous active-high reset
//   push        : write push_data (ignored when full and not popping)
//   push_data   : entry to store
//   pop         : consume the head entry (ignored when empty)
//   head_data   : head entry, driven straight from the storage flops; 0 when empty
//   not_empty   : head_data is valid
//   count       : number of stored entries
module stream_credit_fifo
  import img_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = SEQ_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head_data,
  output logic                           not_empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DEPTH-1:0] wr_sel;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    assign wr_sel[gi] = do_push && (wr_ptr_reg == PTR_W'(gi));
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) mem_reg[i] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign not_empty = (count_reg != '0);
  assign head_data = not_empty ? mem_reg[rd_ptr_reg] : '0;
  assign count     = count_reg;

endmodule

// File: rtl/img_stream_seq.sv
// Frame sequencer between a 1-cycle-latency pixel source and an
// AXI4-Stream video consumer. Waits START_DELAY cycles after start, reads
// IMG_WIDTH x IMG_HEIGHT pixels per frame with H_BLANK / V_BLANK idle
// cycles between lines / frames, tags each pixel (tuser = SOF, tlast = EOL)
// and buffers it in a 4-entry FIFO. Reads are only issued while the FIFO
// plus the one possible in-flight read fit, so the FIFO cannot overflow.
//   clk, reset        : clock, asynchronous active-high reset
//   start             : 1-cycle pulse, accepted only in IDLE
//   src_rd_en         : read request to the pixel source
//   src_valid/src_data: source response, one cycle after src_rd_en
//   m_axis_*          : AXI4-Stream video output
//   busy              : sequencing in progress or pixels still buffered
//   frame_done        : 1-cycle pulse after a frame's last pixel handshakes
//   frame_cnt         : completed frames (wraps)
//   err               : sticky, source delivered data nobody asked for
module img_stream_seq
  import img_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 2560,
  parameter int IMG_HEIGHT  = 1440,
  parameter int START_DELAY = 16,
  parameter int H_BLANK     = 0,
  parameter int V_BLANK     = 0,
  parameter int NUM_FRAMES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  src_rd_en,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  err
);

  localparam int COL_W   = clog2_min1(IMG_WIDTH);
  localparam int ROW_W   = clog2_min1(IMG_HEIGHT);
  localparam int MAX_D0  = (START_DELAY > H_BLANK) ? START_DELAY : H_BLANK;
  localparam int MAX_D1  = (MAX_D0 > V_BLANK) ? MAX_D0 : V_BLANK;
  localparam int MAX_DLY = (MAX_D1 > 1) ? MAX_D1 : 1;
  localparam int DLY_W   = $clog2(MAX_DLY) + 1;
  localparam int FIFO_W  = DATA_WIDTH + 2;
  localparam int FCNT_W  = $clog2(SEQ_FIFO_DEPTH + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  seq_state_t        state_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [DLY_W-1:0]  dly_reg;
  logic [31:0]       frames_issued_reg;
  logic              inflight_reg;
  pix_tag_t          tag_reg;
  pix_tag_t          issue_tag;
  logic [ROW_W-1:0]  out_row_reg;
  logic              frame_done_reg;
  logic [15:0]       frame_cnt_reg;
  logic              err_reg;

  logic              credit_ok;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_not_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [FIFO_W-1:0] fifo_head;

  function automatic logic more_frames(input logic [31:0] issued);
    return (NUM_FRAMES == 0) || (issued < 32'(NUM_FRAMES));
  endfunction

  // Buffered pixels plus the read still on its way must fit in the FIFO.
  assign credit_ok = (int'(fifo_count) + int'(inflight_reg)) < SEQ_FIFO_DEPTH;
  assign src_rd_en = (state_reg == ST_ACTIVE) && credit_ok;

  assign issue_tag.sof = (row_reg == '0) && (col_reg == '0);
  assign issue_tag.eol = (col_reg == COL_LAST);

  // Sequencer FSM with row/column/blanking counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      col_reg           <= '0;
      row_reg           <= '0;
      dly_reg           <= '0;
      frames_issued_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            col_reg           <= '0;
            row_reg           <= '0;
            frames_issued_reg <= '0;
            if (START_DELAY == 0) begin
              state_reg <= ST_ACTIVE;
            end else begin
              state_reg <= ST_DELAY;
              dly_reg   <= DLY_W'(START_DELAY - 1);
            end
          end
        end
        ST_DELAY: begin
          if (dly_reg == '0) state_reg <= ST_ACTIVE;
          else               dly_reg   <= dly_reg - 1'b1;
        end
        ST_ACTIVE: begin
          if (src_rd_en) begin
            if (col_reg != COL_LAST) begin
              col_reg <= col_reg + 1'b1;
            end else if (row_reg != ROW_LAST) begin
              if (H_BLANK == 0) begin
                row_reg <= row_reg + 1'b1;
                col_reg <= '0;
              end else begin
                state_reg <= ST_HBLANK;
                dly_reg   <= DLY_W'(H_BLANK - 1);
              end
            end else begin
              frames_issued_reg <= frames_issued_reg + 32'd1;
              if (V_BLANK == 0) begin
                row_reg <= '0;
                col_reg <= '0;
                if (!more_frames(frames_issued_reg + 32'd1)) state_reg <= ST_DONE;
              end else begin
                state_reg <= ST_VBLANK;
                dly_reg   <= DLY_W'(V_BLANK - 1);
              end
            end
          end
        end
        ST_HBLANK: begin
          if (dly_reg == '0) begin
            state_reg <= ST_ACTIVE;
            row_reg   <= row_reg + 1'b1;
            col_reg   <= '0;
          end else begin
            dly_reg <= dly_reg - 1'b1;
          end
        end
        ST_VBLANK: begin
          if (dly_reg == '0) begin
            row_reg   <= '0;
            col_reg   <= '0;
            state_reg <= more_frames(frames_issued_reg) ? ST_ACTIVE : ST_DONE;
          end else begin
            dly_reg <= dly_reg - 1'b1;
          end
        end
        ST_DONE: begin
          // Stay here until every issued pixel has left the block.
          if ((fifo_count == '0) && !inflight_reg) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Tags travel one cycle behind the read to line up with src_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_reg <= 1'b0;
      tag_reg      <= '0;
      err_reg      <= 1'b0;
    end else begin
      inflight_reg <= src_rd_en;
      if (src_rd_en) tag_reg <= issue_tag;
      if (src_valid && !inflight_reg) err_reg <= 1'b1;
    end
  end

  assign fifo_push = src_valid && inflight_reg;
  assign fifo_pop  = fifo_not_empty && m_axis_tready;

  stream_credit_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (SEQ_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({tag_reg.sof, tag_reg.eol, src_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  // The tag carries no end-of-frame bit, so lines are counted at the
  // output to recognise the last line of each frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_row_reg    <= '0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      if (fifo_pop && fifo_head[DATA_WIDTH]) begin
        if (out_row_reg == ROW_LAST) begin
          out_row_reg    <= '0;
          frame_done_reg <= 1'b1;
          frame_cnt_reg  <= frame_cnt_reg + 16'd1;
        end else begin
          out_row_reg <= out_row_reg + 1'b1;
        end
      end
    end
  end

  assign m_axis_tvalid = fifo_not_empty;
  assign m_axis_tdata  = fifo_head[DATA_WIDTH-1:0];
  assign m_axis_tlast  = fifo_head[DATA_WIDTH];
  assign m_axis_tuser  = fifo_head[DATA_WIDTH+1];
  assign frame_done    = frame_done_reg;
  assign frame_cnt     = frame_cnt_reg;
  assign err           = err_reg;
  assign busy          = ((state_reg != ST_IDLE) && (state_reg != ST_DONE))
                         || fifo_not_empty || inflight_reg;

endmodule
